// File: rtl/stream_pkg.sv
// Shared types and mask helpers for the stream width converters.
// Masks are zero-extended to MAX_LANES so one set of functions serves every ratio.
package stream_pkg;

  localparam int unsigned MAX_LANES = 64;
  localparam int unsigned MAX_IDX_W = 6;

  typedef logic [MAX_LANES-1:0] lane_mask_t;
  typedef logic [MAX_IDX_W-1:0] lane_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ds_state_e;

  function automatic lane_idx_t lowest_set_idx(input lane_mask_t mask);
    lane_idx_t idx;
    idx = '0;
    // Descending scan so the lowest set bit is the final assignment.
    for (int unsigned i = MAX_LANES; i > 0; i--) begin
      if (mask[i-1]) idx = lane_idx_t'(i - 1);
    end
    return idx;
  endfunction

  function automatic logic onehot_or_zero(input lane_mask_t mask);
    return (mask & (mask - lane_mask_t'(1))) == '0;
  endfunction

  function automatic logic keep_contiguous(input lane_mask_t mask);
    return (mask != '0) && (((mask + lane_mask_t'(1)) & mask) == '0);
  endfunction

endpackage

// File: rtl/lane_picker.sv
// Combinational priority encoder: selects the lowest remaining lane and
// flags when it is the only lane left.
module lane_picker
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic [T_DATA_RATIO-1:0]         rem_i,
  output logic [$clog2(T_DATA_RATIO)-1:0] sel_o,
  output logic                            last_lane_o
);

  lane_mask_t mask_ext;

  always_comb begin
    mask_ext                 = '0;
    mask_ext[T_DATA_RATIO-1:0] = rem_i;
    sel_o                    = ($clog2(T_DATA_RATIO))'(lowest_set_idx(mask_ext));
    last_lane_o              = onehot_or_zero(mask_ext) && (rem_i != '0);
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream serializer emitting kept lanes lowest-first.
// Optional STREAM_DOWNSIZE_KEEP_CHECK_EN adds err_o for non-contiguous keep.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 1,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  ,
  output logic                    err_o
`endif
);

  localparam int unsigned IDX_W = $clog2(T_DATA_RATIO);

  ds_state_e                 state_q, state_d;
  logic [T_DATA_RATIO-1:0]   rem_q, rem_d;
  logic [T_DATA_WIDTH-1:0]   buf_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0]   buf_d [T_DATA_RATIO-1:0];
  logic                      buf_last_q, buf_last_d;

  logic [IDX_W-1:0]          sel;
  logic                      last_lane;
  logic                      m_fire;
  logic                      s_fire;

  lane_picker #(
    .T_DATA_RATIO (T_DATA_RATIO)
  ) u_lane_picker (
    .rem_i       (rem_q),
    .sel_o       (sel),
    .last_lane_o (last_lane)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    buf_d      = buf_q;
    buf_last_d = buf_last_q;

    m_valid_o = (state_q == ST_SEND);
    m_data_o  = buf_q[sel];
    m_last_o  = buf_last_q && last_lane;
    m_fire    = m_valid_o && m_ready_i;
    // Final beat and next-word acceptance share a cycle for zero-bubble flow.
    s_ready_o = (state_q == ST_IDLE) || (m_fire && last_lane);
    s_fire    = s_valid_i && s_ready_o;

    if (m_fire) begin
      rem_d[sel] = 1'b0;
      if (last_lane) state_d = ST_IDLE;
    end

    if (s_fire) begin
      buf_d      = s_data_i;
      rem_d      = s_keep_i;
      buf_last_d = s_last_i;
      state_d    = (s_keep_i != '0) ? ST_SEND : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      buf_q      <= '{default: '0};
      buf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
    end
  end

`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  lane_mask_t keep_ext;
  logic       err_q, err_d;

  always_comb begin
    keep_ext                   = '0;
    keep_ext[T_DATA_RATIO-1:0] = s_keep_i;
    err_d                      = s_fire && !keep_contiguous(keep_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize (W=8, R=4) against a beat-queue model.
module tb_stream_downsize;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data_i [3:0];
  logic [3:0] s_keep_i = '0;
  logic       s_last_i = 1'b0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  logic       err_o;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t       cur[$];
  logic [31:0] word_in = '0;
  logic        exp_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  stream_downsize #(
    .T_DATA_WIDTH (8),
    .T_DATA_RATIO (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_keep_i  (s_keep_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  // Model: expand an accepted word into its list of narrow beats.
  function automatic void model_load(input logic [31:0] d, input logic [3:0] k, input logic l);
    int last_i;
    beat_t b;
    last_i = -1;
    for (int i = 0; i < 4; i++) if (k[i]) last_i = i;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) begin
        b.d = d[8*i +: 8];
        b.l = l && (i == last_i);
        cur.push_back(b);
      end
    end
  endfunction

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic v, input logic r);
    word_in = d;
    for (int i = 0; i < 4; i++) s_data_i[i] = d[8*i +: 8];
    s_keep_i  = k;
    s_last_i  = l;
    s_valid_i = v;
    m_ready_i = r;
  endtask

  // Advance the model across one rising edge, then move to just after it.
  task automatic step();
    logic acc;
    acc = s_valid_i && ((cur.size() == 0) || (m_ready_i && cur.size() == 1));
    if (m_ready_i && cur.size() != 0) void'(cur.pop_front());
    exp_err = acc && !(s_keep_i inside {4'b0001, 4'b0011, 4'b0111, 4'b1111});
    if (acc) model_load(word_in, s_keep_i, s_last_i);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", m_valid_o); end
    checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b exp 0", m_last_o); end
    checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", m_data_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", s_ready_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur.delete();
    exp_err = 1'b0;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL post_reset: ready %b valid %b exp 1 0", s_ready_o, m_valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(32'h4433_2211, 4'b1111, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL full_accept: got %b exp 1", s_ready_o); end
    step();
    drive(32'h4433_2211, 4'b1111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== exp_d[i] || m_last_o !== (i == 3)) begin
        errors++;
        $display("FAIL full_beat%0d: got v%b d%h l%b exp v1 d%h l%b", i, m_valid_o, m_data_o, m_last_o, exp_d[i], i == 3);
      end
      checks++;
      if (s_ready_o !== (i == 3)) begin
        errors++; $display("FAIL full_ready%0d: got %b exp %b", i, s_ready_o, i == 3);
      end
      step();
    end
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL full_done: got %b exp 0", m_valid_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d  [3] = '{8'hA0, 8'hA1, 8'hB0};
    logic       exp_l  [3] = '{1'b0, 1'b0, 1'b1};
    logic       exp_sr [3] = '{1'b0, 1'b1, 1'b1};
    drive(32'h0000_A1A0, 4'b0011, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_acceptA: got %b exp 1", s_ready_o); end
    step();
    drive(32'h0000_00B0, 4'b0001, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(32'h0000_00B0, 4'b0001, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== exp_d[i] || m_last_o !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got v%b d%h l%b exp v1 d%h l%b", i, m_valid_o, m_data_o, m_last_o, exp_d[i], exp_l[i]);
      end
      if (i < 2) begin
        checks++;
        if (s_ready_o !== exp_sr[i]) begin errors++; $display("FAIL b2b_ready%0d: got %b exp %b", i, s_ready_o, exp_sr[i]); end
      end
      step();
    end
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b exp 0", m_valid_o); end
    step();
  endtask

  task automatic test_sparse_keep();
    drive(32'hDDCC_BBAA, 4'b1010, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'hDDCC_BBAA, 4'b1010, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'hBB || m_last_o !== 1'b0) begin
      errors++; $display("FAIL sparse_beat0: got v%b d%h l%b exp v1 dBB l0", m_valid_o, m_data_o, m_last_o);
    end
    step();
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'hDD || m_last_o !== 1'b1) begin
      errors++; $display("FAIL sparse_beat1: got v%b d%h l%b exp v1 dDD l1", m_valid_o, m_data_o, m_last_o);
    end
    step();
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL sparse_done: got %b exp 0", m_valid_o); end
    step();
  endtask

  task automatic test_backpressure();
    int         left;
    int         cyc;
    logic       stall;
    logic [7:0] hold_d;
    logic       hold_l;
    drive($urandom, 4'b0111, 1'b1, 1'b1, 1'b1);
    step();
    drive($urandom, 4'b1111, 1'b0, 1'b1, 1'b0);
    left  = 3;
    cyc   = 0;
    stall = 1'b0;
    while (left > 0 && cyc < 80) begin
      m_ready_i = ($urandom_range(0, 99) < 40);
      @(negedge clk);
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== cur[0].d || m_last_o !== cur[0].l) begin
        errors++;
        $display("FAIL bp_beat: got v%b d%h l%b exp v1 d%h l%b", m_valid_o, m_data_o, m_last_o, cur[0].d, cur[0].l);
      end
      if (stall) begin
        checks++;
        if (m_data_o !== hold_d || m_last_o !== hold_l) begin
          errors++; $display("FAIL bp_stable: got d%h l%b exp d%h l%b", m_data_o, m_last_o, hold_d, hold_l);
        end
      end
      checks++;
      if (s_ready_o !== (m_ready_i && left == 1)) begin
        errors++; $display("FAIL bp_ready: got %b exp %b", s_ready_o, m_ready_i && left == 1);
      end
      stall  = !m_ready_i;
      hold_d = m_data_o;
      hold_l = m_last_o;
      if (m_ready_i) left--;
      step();
      cyc++;
    end
    checks++; if (left != 0) begin errors++; $display("FAIL bp_timeout: got %0d beats left exp 0", left); end
    drain();
  endtask

  task automatic test_zero_keep();
    drive(32'h4433_2211, 4'b0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b exp 1", s_ready_o); end
    step();
    drive(32'h4433_2211, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL zero_valid%0d: got %b exp 0", i, m_valid_o); end
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
      checks++; if (err_o !== (i == 0)) begin errors++; $display("FAIL zero_err%0d: got %b exp %b", i, err_o, i == 0); end
`endif
      step();
    end
    drive(32'h4433_2211, 4'b0101, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h4433_2211, 4'b0101, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid_o !== (i < 2) || (i < 2 && (m_data_o !== (i == 0 ? 8'h11 : 8'h33) || m_last_o !== (i == 1)))) begin
        errors++; $display("FAIL k0101_beat%0d: got v%b d%h l%b", i, m_valid_o, m_data_o, m_last_o);
      end
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
      checks++; if (err_o !== (i == 0)) begin errors++; $display("FAIL k0101_err%0d: got %b exp %b", i, err_o, i == 0); end
`endif
      step();
    end
  endtask

  task automatic test_reset_mid_word();
    drive(32'h4433_2211, 4'b1111, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h4433_2211, 4'b1111, 1'b1, 1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== 8'h00) begin
      errors++; $display("FAIL midrst_async: got v%b l%b d%h exp v0 l0 d00", m_valid_o, m_last_o, m_data_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur.delete();
    exp_err = 1'b0;
    drive(32'h8877_6655, 4'b1111, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got r%b v%b exp r1 v0", s_ready_o, m_valid_o);
    end
    step();
    drive(32'h8877_6655, 4'b1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h55) begin
      errors++; $display("FAIL midrst_lane0: got v%b d%h exp v1 d55", m_valid_o, m_data_o);
    end
    drain();
  endtask

  task automatic test_random();
    logic       stall;
    logic [7:0] hold_d;
    logic       hold_l;
    logic       exp_sr;
    stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
      @(negedge clk);
      exp_sr = (cur.size() == 0) || (m_ready_i && cur.size() == 1);
      checks++;
      if (m_valid_o !== (cur.size() != 0)) begin
        errors++; $display("FAIL rnd_valid: got %b exp %b (cycle %0d)", m_valid_o, cur.size() != 0, c);
      end
      if (cur.size() != 0) begin
        checks++;
        if (m_data_o !== cur[0].d || m_last_o !== cur[0].l) begin
          errors++; $display("FAIL rnd_beat: got d%h l%b exp d%h l%b (cycle %0d)", m_data_o, m_last_o, cur[0].d, cur[0].l, c);
        end
      end
      if (stall) begin
        checks++;
        if (m_data_o !== hold_d || m_last_o !== hold_l) begin
          errors++; $display("FAIL rnd_stable: got d%h l%b exp d%h l%b", m_data_o, m_last_o, hold_d, hold_l);
        end
      end
      checks++;
      if (s_ready_o !== exp_sr) begin errors++; $display("FAIL rnd_ready: got %b exp %b (cycle %0d)", s_ready_o, exp_sr, c); end
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
      checks++;
      if (err_o !== exp_err) begin errors++; $display("FAIL rnd_err: got %b exp %b (cycle %0d)", err_o, exp_err, c); end
`endif
      stall  = m_valid_o && !m_ready_i;
      hold_d = m_data_o;
      hold_l = m_last_o;
      step();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) s_data_i[i] = '0;
    test_reset();
    test_full_word();
    test_back_to_back();
    test_sparse_keep();
    test_backpressure();
    test_zero_keep();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
